pwrseq_boot: RTL and testbench

Parametrised power sequencer and boot controller for the TMS320VC5509A board CPLD. It enables N supply rails in order, qualifies each on its power-good input, holds the DSP in reset with boot-select pins driven, and then releases reset. During boot only, it bridges the DSP SPI boot pins to the boot EEPROM. On power-good loss or timeout it shuts all rails down and latches a fault code.

---
 rtl/pwrseq_pkg.sv | 21 ++
 rtl/pwrseq_boot_if.sv | 22 ++
 rtl/pwrseq_timer.sv | 23 ++
 rtl/pwrseq_boot.sv | 223 ++++++++++++++++++++++
 tb/tb_pwrseq_boot.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/pwrseq_pkg.sv
// Shared types for the power sequencer / boot controller: FSM state encoding
// and latched fault codes.
package pwrseq_pkg;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_RAMP    = 3'd1,
    S_SETTLE  = 3'd2,
    S_RSTHOLD = 3'd3,
    S_BOOT    = 3'd4,
    S_RUN     = 3'd5,
    S_DOWN    = 3'd6,
    S_FAULT   = 3'd7
  } state_t;

  localparam logic [1:0] FLT_NONE    = 2'd0;
  localparam logic [1:0] FLT_PG_TO   = 2'd1;
  localparam logic [1:0] FLT_PG_LOST = 2'd2;
  localparam logic [1:0] FLT_BOOT_TO = 2'd3;

endpackage

// File: rtl/pwrseq_boot_if.sv
// SPI boot bridge pins: DSP master side plus the EEPROM side.
// slave = the CPLD bridge, master = the DSP/EEPROM environment.
interface pwrseq_boot_if;
  logic sclk;
  logic mosi;
  logic cs;
  logic miso;
  logic eeprom_sclk;
  logic eeprom_mosi;
  logic eeprom_mem_cs;
  logic eeprom_miso;

  modport slave (
    input  sclk, mosi, cs, eeprom_miso,
    output miso, eeprom_sclk, eeprom_mosi, eeprom_mem_cs
  );

  modport master (
    output sclk, mosi, cs, eeprom_miso,
    input  miso, eeprom_sclk, eeprom_mosi, eeprom_mem_cs
  );
endinterface

// File: rtl/pwrseq_timer.sv
// Loadable down-counter shared by every timed state. Loading D gives an
// expiry flag on the D-th cycle after the load edge.
module pwrseq_timer #(
  parameter int DLY_W = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             load,
  input  logic [DLY_W-1:0] val,
  output logic             expired
);

  logic [DLY_W-1:0] cnt;

  always_ff @(posedge clk_in) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= val - 1'b1;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/pwrseq_boot.sv
// Rail power sequencer and DSP boot controller with gated SPI boot bridge.
// Define PWRSEQ_BOOT_WDOG_EN to add the boot watchdog (BOOT_TO cycles).
module pwrseq_boot
  import pwrseq_pkg::*;
#(
  parameter int         N_RAILS  = 2,
  parameter int         DLY_W    = 16,
  parameter int         RAIL_DLY = 1000,
  parameter int         PG_TO    = 5000,
  parameter int         RST_HOLD = 100,
  parameter logic [3:0] BOOTCFG  = 4'b1001,
  parameter int         BOOT_TO  = 50000
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               en,
  input  logic [N_RAILS-1:0] pg,
  input  logic               boot_done,
  output logic [N_RAILS-1:0] pwr_en,
  output logic               dsp_rst_n,
  output logic [3:0]         bootcfg,
  output logic               bootcfg_oe,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic [2:0]         state,
  pwrseq_boot_if.slave       spi
);

`ifdef PWRSEQ_BOOT_WDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  localparam int                 RW  = (N_RAILS > 1) ? $clog2(N_RAILS) : 1;
  localparam logic [N_RAILS-1:0] ONE = 1;

  logic [N_RAILS-1:0] pg_m, pg_s;
  logic               bd_m, bd_s;

  state_t             st_q, st_d;
  logic [RW-1:0]      rail_q, rail_d;
  logic [N_RAILS-1:0] pe_q, pe_d, qual;
  logic               rn_q, rn_d, oe_q, oe_d, f_q, f_d;
  logic [1:0]         fc_q, fc_d, flt_code;
  logic               flt, down, lost;
  logic               t_load, t_exp;
  logic [DLY_W-1:0]   t_val;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      pg_m <= '0;
      pg_s <= '0;
      bd_m <= 1'b0;
      bd_s <= 1'b0;
    end else begin
      pg_m <= pg;
      pg_s <= pg_m;
      bd_m <= boot_done;
      bd_s <= bd_m;
    end
  end

  pwrseq_timer #(.DLY_W(DLY_W)) u_timer (
    .clk_in  (clk_in),
    .rst     (rst),
    .load    (t_load),
    .val     (t_val),
    .expired (t_exp)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      st_q   <= S_OFF;
      rail_q <= '0;
      pe_q   <= '0;
      rn_q   <= 1'b0;
      oe_q   <= 1'b0;
      f_q    <= 1'b0;
      fc_q   <= FLT_NONE;
    end else begin
      st_q   <= st_d;
      rail_q <= rail_d;
      pe_q   <= pe_d;
      rn_q   <= rn_d;
      oe_q   <= oe_d;
      f_q    <= f_d;
      fc_q   <= fc_d;
    end
  end

  always_comb begin
    st_d     = st_q;
    rail_d   = rail_q;
    pe_d     = pe_q;
    rn_d     = rn_q;
    oe_d     = oe_q;
    f_d      = f_q;
    fc_d     = fc_q;
    t_load   = 1'b0;
    t_val    = DLY_W'(RAIL_DLY);
    flt      = 1'b0;
    flt_code = FLT_NONE;
    down     = 1'b0;

    // Rails already qualified: below the current one while ramping, up to and
    // including it once settling, and all of them after sequencing completes.
    for (int k = 0; k < N_RAILS; k++) begin
      unique case (st_q)
        S_RAMP:                    qual[k] = (k < int'(rail_q));
        S_SETTLE:                  qual[k] = (k <= int'(rail_q));
        S_RSTHOLD, S_BOOT, S_RUN:  qual[k] = 1'b1;
        default:                   qual[k] = 1'b0;
      endcase
    end
    lost = |(qual & ~pg_s);

    unique case (st_q)
      S_OFF: if (en) begin
        rail_d = '0;
        pe_d   = ONE;
        f_d    = 1'b0;
        fc_d   = FLT_NONE;
        t_load = 1'b1;
        t_val  = DLY_W'(PG_TO);
        st_d   = S_RAMP;
      end
      S_RAMP: begin
        if (lost)                         begin flt = 1'b1; flt_code = FLT_PG_LOST; end
        else if (!pg_s[rail_q] && t_exp) begin flt = 1'b1; flt_code = FLT_PG_TO;   end
        else if (!en)                     down = 1'b1;
        else if (pg_s[rail_q]) begin
          t_load = 1'b1;
          st_d   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (lost)       begin flt = 1'b1; flt_code = FLT_PG_LOST; end
        else if (!en)   down = 1'b1;
        else if (t_exp) begin
          t_load = 1'b1;
          if (int'(rail_q) < N_RAILS-1) begin
            rail_d = rail_q + 1'b1;
            pe_d   = pe_q | (ONE << (rail_q + 1'b1));
            t_val  = DLY_W'(PG_TO);
            st_d   = S_RAMP;
          end else begin
            t_val  = DLY_W'(RST_HOLD);
            oe_d   = 1'b1;
            st_d   = S_RSTHOLD;
          end
        end
      end
      S_RSTHOLD: begin
        if (lost)       begin flt = 1'b1; flt_code = FLT_PG_LOST; end
        else if (!en)   down = 1'b1;
        else if (t_exp) begin
          rn_d   = 1'b1;
          t_load = WDOG_EN;
          t_val  = DLY_W'(BOOT_TO);
          st_d   = S_BOOT;
        end
      end
      S_BOOT: begin
        if (lost)                  begin flt = 1'b1; flt_code = FLT_PG_LOST; end
        else if (WDOG_EN && t_exp) begin flt = 1'b1; flt_code = FLT_BOOT_TO; end
        else if (!en)              down = 1'b1;
        else if (bd_s) begin
          oe_d = 1'b0;
          st_d = S_RUN;
        end
      end
      S_RUN: begin
        if (lost)     begin flt = 1'b1; flt_code = FLT_PG_LOST; end
        else if (!en) down = 1'b1;
      end
      // Rails come down highest first, one RAIL_DLY apart; en is ignored here.
      S_DOWN: if (t_exp) begin
        if (rail_q == '0) st_d = S_OFF;
        else begin
          rail_d = rail_q - 1'b1;
          pe_d   = pe_q & ~(ONE << (rail_q - 1'b1));
          t_load = 1'b1;
        end
      end
      S_FAULT: if (!en) st_d = S_OFF;
      default: st_d = S_OFF;
    endcase

    if (flt) begin
      st_d = S_FAULT;
      pe_d = '0;
      rn_d = 1'b0;
      oe_d = 1'b0;
      f_d  = 1'b1;
      fc_d = flt_code;
    end else if (down) begin
      st_d   = S_DOWN;
      pe_d   = pe_q & ~(ONE << rail_q);
      rn_d   = 1'b0;
      oe_d   = 1'b0;
      t_load = 1'b1;
      t_val  = DLY_W'(RAIL_DLY);
    end
  end

  assign pwr_en     = pe_q;
  assign dsp_rst_n  = rn_q;
  assign bootcfg    = BOOTCFG;
  assign bootcfg_oe = oe_q;
  assign fault      = f_q;
  assign fault_code = fc_q;
  assign state      = st_q;

  // Bridge passes data only while booting; otherwise EEPROM is deselected.
  logic bridge;
  assign bridge            = (st_q == S_BOOT);
  assign spi.eeprom_sclk   = bridge & spi.sclk;
  assign spi.eeprom_mosi   = bridge & spi.mosi;
  assign spi.eeprom_mem_cs = ~bridge | spi.cs;
  assign spi.miso          = bridge & spi.eeprom_miso;

endmodule

// File: tb/tb_pwrseq_boot.sv
// Directed bench for pwrseq_boot: table-driven power-up plus hand sequences
// for shutdown, faults, bridge gating, watchdog and mid-run reset.
module tb_pwrseq_boot;
  import pwrseq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       bd  = 1'b0;
  logic [1:0] pg  = 2'b00;
  logic [1:0] pwr_en;
  logic       dsp_rst_n, bootcfg_oe, fault;
  logic [3:0] bootcfg;
  logic [1:0] fault_code;
  logic [2:0] state;

  pwrseq_boot_if spi_if ();

  pwrseq_boot #(
    .N_RAILS(2), .DLY_W(16), .RAIL_DLY(4), .PG_TO(10), .RST_HOLD(3),
    .BOOTCFG(4'b1001), .BOOT_TO(20)
  ) dut (
    .clk_in(clk), .rst(rst), .en(en), .pg(pg), .boot_done(bd),
    .pwr_en(pwr_en), .dsp_rst_n(dsp_rst_n), .bootcfg(bootcfg),
    .bootcfg_oe(bootcfg_oe), .fault(fault), .fault_code(fault_code),
    .state(state), .spi(spi_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [1:0] pg;
    logic       bd;
    int         n;
    logic [1:0] pe;
    logic       rn;
    logic       oe;
    logic       f;
    logic [1:0] fc;
    logic [2:0] st;
  } vec_t;

  vec_t tbl[16];
  int   n_run  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic e, logic [1:0] p, logic b, int n, logic [1:0] pe,
                              logic rn, logic oe, logic f, logic [1:0] fc, logic [2:0] st);
    vec_t v;
    v.en = e; v.pg = p; v.bd = b; v.n = n;
    v.pe = pe; v.rn = rn; v.oe = oe; v.f = f; v.fc = fc; v.st = st;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Packed view {pwr_en, dsp_rst_n, bootcfg_oe, fault, fault_code, state, bootcfg}
  task automatic chk(input string name, input logic [1:0] pe, input logic rn, input logic oe,
                     input logic f, input logic [1:0] fc, input logic [2:0] st);
    check(name, {18'd0, pwr_en, dsp_rst_n, bootcfg_oe, fault, fault_code, state, bootcfg},
                {18'd0, pe, rn, oe, f, fc, st, 4'b1001});
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      en = tbl[i].en; pg = tbl[i].pg; bd = tbl[i].bd;
      step(tbl[i].n);
      chk($sformatf("vec%0d", i), tbl[i].pe, tbl[i].rn, tbl[i].oe, tbl[i].f, tbl[i].fc, tbl[i].st);
    end
  endtask

  task automatic spi_drive(input logic s, input logic m, input logic c, input logic em);
    spi_if.sclk = s; spi_if.mosi = m; spi_if.cs = c; spi_if.eeprom_miso = em;
    #1;
  endtask

  initial begin
    //            en  pg    bd  n   pe    rn  oe  f   fc  st
    tbl[0]  = mk(1, 2'b00, 0, 1, 2'b01, 0, 0, 0, 0, S_RAMP);
    tbl[1]  = mk(1, 2'b00, 0, 2, 2'b01, 0, 0, 0, 0, S_RAMP);
    tbl[2]  = mk(1, 2'b01, 0, 2, 2'b01, 0, 0, 0, 0, S_RAMP);
    tbl[3]  = mk(1, 2'b01, 0, 1, 2'b01, 0, 0, 0, 0, S_SETTLE);
    tbl[4]  = mk(1, 2'b01, 0, 3, 2'b01, 0, 0, 0, 0, S_SETTLE);
    tbl[5]  = mk(1, 2'b01, 0, 1, 2'b11, 0, 0, 0, 0, S_RAMP);
    tbl[6]  = mk(1, 2'b11, 0, 2, 2'b11, 0, 0, 0, 0, S_RAMP);
    tbl[7]  = mk(1, 2'b11, 0, 1, 2'b11, 0, 0, 0, 0, S_SETTLE);
    tbl[8]  = mk(1, 2'b11, 0, 3, 2'b11, 0, 0, 0, 0, S_SETTLE);
    tbl[9]  = mk(1, 2'b11, 0, 1, 2'b11, 0, 1, 0, 0, S_RSTHOLD);
    tbl[10] = mk(1, 2'b11, 0, 2, 2'b11, 0, 1, 0, 0, S_RSTHOLD);
    tbl[11] = mk(1, 2'b11, 0, 1, 2'b11, 1, 1, 0, 0, S_BOOT);
    tbl[12] = mk(1, 2'b11, 0, 5, 2'b11, 1, 1, 0, 0, S_BOOT);
    tbl[13] = mk(1, 2'b11, 1, 2, 2'b11, 1, 1, 0, 0, S_BOOT);
    tbl[14] = mk(1, 2'b11, 1, 1, 2'b11, 1, 0, 0, 0, S_RUN);
    tbl[15] = mk(1, 2'b11, 0, 3, 2'b11, 1, 0, 0, 0, S_RUN);

    spi_drive(1'b0, 1'b0, 1'b1, 1'b0);
    step(3);
    chk("reset_state", 2'b00, 0, 0, 0, FLT_NONE, S_OFF);
    check("reset_bridge", {28'd0, spi_if.eeprom_mem_cs, spi_if.eeprom_sclk, spi_if.eeprom_mosi, spi_if.miso},
                          {28'd0, 4'b1000});
    rst = 1'b0;
    step(2);
    chk("idle_off", 2'b00, 0, 0, 0, FLT_NONE, S_OFF);

    // Nominal power-up to BOOT, then bridge pass-through.
    run_vecs(0, 12);
    spi_drive(1'b1, 1'b0, 1'b0, 1'b1);
    check("boot_bridge_a", {28'd0, spi_if.eeprom_mem_cs, spi_if.eeprom_sclk, spi_if.eeprom_mosi, spi_if.miso},
                           {28'd0, 4'b0101});
    spi_drive(1'b0, 1'b1, 1'b1, 1'b0);
    check("boot_bridge_b", {28'd0, spi_if.eeprom_mem_cs, spi_if.eeprom_sclk, spi_if.eeprom_mosi, spi_if.miso},
                           {28'd0, 4'b1010});
    spi_drive(1'b0, 1'b0, 1'b1, 1'b0);
    run_vecs(13, 15);
    spi_drive(1'b1, 1'b1, 1'b0, 1'b1);
    check("run_bridge_off", {28'd0, spi_if.eeprom_mem_cs, spi_if.eeprom_sclk, spi_if.eeprom_mosi, spi_if.miso},
                            {28'd0, 4'b1000});
    spi_drive(1'b0, 1'b0, 1'b1, 1'b0);

    // Ordered shutdown from RUN; en re-asserted mid-DOWN is ignored.
    en = 1'b0;
    step(1); chk("down_entry", 2'b01, 0, 0, 0, FLT_NONE, S_DOWN);
    step(3); chk("down_hold1", 2'b01, 0, 0, 0, FLT_NONE, S_DOWN);
    step(1); chk("down_rail0", 2'b00, 0, 0, 0, FLT_NONE, S_DOWN);
    en = 1'b1;
    step(3); chk("down_hold0", 2'b00, 0, 0, 0, FLT_NONE, S_DOWN);
    en = 1'b0;
    step(1); chk("down_off", 2'b00, 0, 0, 0, FLT_NONE, S_OFF);
    pg = 2'b00;
    step(3); chk("off_idle", 2'b00, 0, 0, 0, FLT_NONE, S_OFF);

    // Power back up to RUN, then lose rail 0.
    run_vecs(0, 15);
    pg = 2'b10;
    step(3); chk("pg_lost", 2'b00, 0, 0, 1, FLT_PG_LOST, S_FAULT);
    step(3); chk("fault_hold", 2'b00, 0, 0, 1, FLT_PG_LOST, S_FAULT);
    en = 1'b0; pg = 2'b00;
    step(1); chk("fault_off", 2'b00, 0, 0, 1, FLT_PG_LOST, S_OFF);
    step(2);

    // PG timeout on rail 0.
    en = 1'b1;
    step(1); chk("to_ramp", 2'b01, 0, 0, 0, FLT_NONE, S_RAMP);
    step(9); chk("to_last", 2'b01, 0, 0, 0, FLT_NONE, S_RAMP);
    step(1); chk("pg_timeout", 2'b00, 0, 0, 1, FLT_PG_TO, S_FAULT);
    step(2); chk("to_sticky", 2'b00, 0, 0, 1, FLT_PG_TO, S_FAULT);
    en = 1'b0;
    step(1); chk("to_off", 2'b00, 0, 0, 1, FLT_PG_TO, S_OFF);
    en = 1'b1;
    step(1); chk("to_clear", 2'b01, 0, 0, 0, FLT_NONE, S_RAMP);
    en = 1'b0;
    step(1); chk("ramp_abort", 2'b00, 0, 0, 0, FLT_NONE, S_DOWN);
    step(4); chk("ramp_abort_off", 2'b00, 0, 0, 0, FLT_NONE, S_OFF);

    // Boot watchdog: no boot_done after BOOT entry.
    run_vecs(0, 12);
    step(14); chk("wd_pre", 2'b11, 1, 1, 0, FLT_NONE, S_BOOT);
`ifdef PWRSEQ_BOOT_WDOG_EN
    step(1);  chk("wd_fault", 2'b00, 0, 0, 1, FLT_BOOT_TO, S_FAULT);
`else
    step(30); chk("wd_none", 2'b11, 1, 1, 0, FLT_NONE, S_BOOT);
`endif
    en = 1'b0; pg = 2'b00;
    step(12);
    check("wd_cleanup_state", {29'd0, state}, {29'd0, S_OFF});

    // Synchronous reset mid-ramp drops the rail immediately.
    en = 1'b1;
    step(1); chk("rst_pre", 2'b01, 0, 0, dut.f_q, fault_code, S_RAMP);
    rst = 1'b1;
    step(1); chk("rst_mid", 2'b00, 0, 0, 0, FLT_NONE, S_OFF);
    rst = 1'b0; en = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
